// File: rtl/scalar_mult_ladder_if.sv
// Bundles the request/result and ECPA/ECPD engine handshakes of scalar_mult_ladder.
// master: key/control logic plus the engine pair; slave: the ladder controller.
// Optional o_steps exists only when SCALAR_MULT_PERF_EN is defined.
interface scalar_mult_ladder_if #(
    parameter int WIDTH = 256,
    parameter int KBITS = 256
) ();
    logic                   i_start;
    logic [KBITS-1:0]       i_k;
    logic [WIDTH-1:0]       i_x;
    logic [WIDTH-1:0]       i_y;
    logic [WIDTH-1:0]       i_z;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_inf;
    logic [WIDTH-1:0]       o_x;
    logic [WIDTH-1:0]       o_y;
    logic [WIDTH-1:0]       o_z;
    logic                   o_add_start;
    logic [3*WIDTH-1:0]     o_add_a;
    logic [3*WIDTH-1:0]     o_add_b;
    logic                   i_add_done;
    logic [3*WIDTH-1:0]     i_add_r;
    logic                   o_dbl_start;
    logic [3*WIDTH-1:0]     o_dbl_a;
    logic                   i_dbl_done;
    logic [3*WIDTH-1:0]     i_dbl_r;
`ifdef SCALAR_MULT_PERF_EN
    logic [$clog2(KBITS):0] o_steps;
`endif

    modport master (
        output i_start, i_k, i_x, i_y, i_z,
        output i_add_done, i_add_r, i_dbl_done, i_dbl_r,
        input  o_busy, o_done, o_inf, o_x, o_y, o_z,
        input  o_add_start, o_add_a, o_add_b, o_dbl_start, o_dbl_a
`ifdef SCALAR_MULT_PERF_EN
        , input o_steps
`endif
    );

    modport slave (
        input  i_start, i_k, i_x, i_y, i_z,
        input  i_add_done, i_add_r, i_dbl_done, i_dbl_r,
        output o_busy, o_done, o_inf, o_x, o_y, o_z,
        output o_add_start, o_add_a, o_add_b, o_dbl_start, o_dbl_a
`ifdef SCALAR_MULT_PERF_EN
        , output o_steps
`endif
    );
endinterface

// File: rtl/scalar_mult_ladder.sv
// Montgomery-ladder scalar multiplier kP driving external point-add and
// point-double engines. Leading zeros of k are skipped one bit per cycle, then
// each ladder step launches add and double together and commits once both
// results are in. Define SCALAR_MULT_PERF_EN to get the o_steps counter.
module scalar_mult_ladder #(
    parameter int WIDTH = 256,
    parameter int KBITS = 256,
    parameter int IDXW  = $clog2(KBITS)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    scalar_mult_ladder_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        INIT_DBL,
        STEP_ISSUE,
        STEP_WAIT,
        FINISH
    } state_t;

    state_t             state;
    logic [KBITS-1:0]   k_reg;
    logic [3*WIDTH-1:0] p_reg;
    logic [3*WIDTH-1:0] r0;
    logic [3*WIDTH-1:0] r1;
    logic [3*WIDTH-1:0] add_hold;
    logic [3*WIDTH-1:0] dbl_hold;
    logic               add_flag;
    logic               dbl_flag;
    logic [IDXW-1:0]    idx;
    logic               k_bit;

    // Scalar bit currently being scanned or processed by the ladder.
    assign k_bit = k_reg[idx];

    // Ladder controller: single registered FSM, all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            k_reg           <= '0;
            p_reg           <= '0;
            r0              <= '0;
            r1              <= '0;
            add_hold        <= '0;
            dbl_hold        <= '0;
            add_flag        <= 1'b0;
            dbl_flag        <= 1'b0;
            idx             <= '0;
            bus.o_busy      <= 1'b0;
            bus.o_done      <= 1'b0;
            bus.o_inf       <= 1'b0;
            bus.o_x         <= '0;
            bus.o_y         <= '0;
            bus.o_z         <= '0;
            bus.o_add_start <= 1'b0;
            bus.o_add_a     <= '0;
            bus.o_add_b     <= '0;
            bus.o_dbl_start <= 1'b0;
            bus.o_dbl_a     <= '0;
`ifdef SCALAR_MULT_PERF_EN
            bus.o_steps     <= '0;
`endif
        end else begin
            // Start and done outputs are single-cycle pulses by default.
            bus.o_add_start <= 1'b0;
            bus.o_dbl_start <= 1'b0;
            bus.o_done      <= 1'b0;
            case (state)
                IDLE: begin
                    bus.o_busy <= 1'b0;
                    // o_busy is still high in the done cycle, so a start there is ignored.
                    if (bus.i_start && !bus.o_busy) begin
                        k_reg      <= bus.i_k;
                        p_reg      <= {bus.i_x, bus.i_y, bus.i_z};
                        idx        <= IDXW'(KBITS - 1);
                        bus.o_busy <= 1'b1;
                        bus.o_inf  <= 1'b0;
`ifdef SCALAR_MULT_PERF_EN
                        bus.o_steps <= '0;
`endif
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (k_bit) begin
                        if (idx == '0) begin
                            // k = 1: result is P itself, no engine work.
                            r0    <= p_reg;
                            state <= FINISH;
                        end else begin
                            // idx now holds the top set bit m; seed R1 = 2P.
                            bus.o_dbl_start <= 1'b1;
                            bus.o_dbl_a     <= p_reg;
                            state           <= INIT_DBL;
                        end
                    end else if (idx == '0) begin
                        bus.o_inf <= 1'b1;
                        r0        <= '0;
                        state     <= FINISH;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                INIT_DBL: begin
                    if (bus.i_dbl_done) begin
                        r0    <= p_reg;
                        r1    <= bus.i_dbl_r;
                        idx   <= idx - IDXW'(1);
`ifdef SCALAR_MULT_PERF_EN
                        bus.o_steps <= bus.o_steps + 1'b1;
`endif
                        state <= STEP_ISSUE;
                    end
                end
                STEP_ISSUE: begin
                    bus.o_add_start <= 1'b1;
                    bus.o_add_a     <= r0;
                    bus.o_add_b     <= r1;
                    bus.o_dbl_start <= 1'b1;
                    bus.o_dbl_a     <= k_bit ? r1 : r0;
                    add_flag        <= 1'b0;
                    dbl_flag        <= 1'b0;
                    state           <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    if (add_flag && dbl_flag) begin
                        // Commit the step; extra done pulses this cycle are dropped.
                        if (k_bit) begin
                            r0 <= add_hold;
                            r1 <= dbl_hold;
                        end else begin
                            r1 <= add_hold;
                            r0 <= dbl_hold;
                        end
                        add_flag <= 1'b0;
                        dbl_flag <= 1'b0;
`ifdef SCALAR_MULT_PERF_EN
                        bus.o_steps <= bus.o_steps + 1'b1;
`endif
                        if (idx == '0) begin
                            state <= FINISH;
                        end else begin
                            idx   <= idx - IDXW'(1);
                            state <= STEP_ISSUE;
                        end
                    end else begin
                        // Results may return in either order or together.
                        if (bus.i_add_done && !add_flag) begin
                            add_hold <= bus.i_add_r;
                            add_flag <= 1'b1;
                        end
                        if (bus.i_dbl_done && !dbl_flag) begin
                            dbl_hold <= bus.i_dbl_r;
                            dbl_flag <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    bus.o_x    <= r0[3*WIDTH-1 -: WIDTH];
                    bus.o_y    <= r0[2*WIDTH-1 -: WIDTH];
                    bus.o_z    <= r0[WIDTH-1:0];
                    bus.o_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
